auto_guesser: RTL and testbench
===============================

AUTO_GUESSER -- requirements
Module: auto_guesser

Interface
REQ-001 Parameter RESP_LAT, default 2: clock cycles from the o_enter pulse to feedback sampling; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  begin a new search; sampled only in IDLE, DONE or FAIL.
REQ-005 i_over  input  1  feedback: last guess > secret value.
REQ-006 i_under  input  1  feedback: last guess < secret value.
REQ-007 i_equal  input  1  feedback: last guess == secret value.
REQ-008 o_guess  output  8  current guess, unsigned.
REQ-009 o_enter  output  1  single-cycle "guess submitted" strobe.
REQ-010 o_done  output  1  high in DONE; o_guess then holds the secret value.
REQ-011 o_fail  output  1  high in FAIL: inconsistent feedback.
REQ-012 o_count  output  4  number of guesses submitted in the current search.

Function
REQ-013 States: IDLE, SETUP, ENTER, WAIT, EVAL, DONE, FAIL.
REQ-014 Search bounds lo, hi are 8-bit registers; a search starts with lo=0, hi=255.
REQ-015 Guess computation: o_guess = (lo + hi) >> 1, using a 9-bit sum with no overflow; registered on entry to SETUP.
REQ-016 IDLE/DONE/FAIL with i_start=1 -> SETUP next cycle; the start also loads lo=0, hi=255, o_count=0 and clears o_done/o_fail.
REQ-017 SETUP: one cycle; o_guess is stable and o_enter=0 (setup time for the consumer) -> ENTER.
REQ-018 ENTER: o_enter=1 for exactly one cycle; o_count increments -> WAIT.
REQ-019 WAIT: hold for RESP_LAT cycles, counted from the cycle after ENTER -> EVAL; o_guess is held constant from SETUP through EVAL.
REQ-020 EVAL, one-hot {i_over,i_under,i_equal} checked in priority order:
  - i_equal -> DONE.
  - i_over with o_guess==0 -> FAIL; else hi = o_guess-1 -> SETUP.
  - i_under with o_guess==255 -> FAIL; else lo = o_guess+1 -> SETUP.
REQ-021 EVAL with zero flags or more than one flag asserted -> FAIL; lo and hi are unchanged.
REQ-022 If an update in EVAL would make lo > hi, the next state is FAIL instead of SETUP.
REQ-023 If o_count==15 in EVAL and i_equal=0 -> FAIL; o_count never wraps.
REQ-024 i_start is ignored in SETUP, ENTER, WAIT and EVAL; a search is never restarted mid-flight.
REQ-025 DONE and FAIL hold o_guess and o_count until the next i_start or reset.
REQ-026 o_enter is never high in consecutive cycles.
REQ-027 For any consistent secret value in 0..255, DONE is reached within 9 guesses.
REQ-028 Each guess occupies 3+RESP_LAT cycles: SETUP, ENTER, RESP_LAT WAIT cycles, EVAL.

Reset
REQ-029 Reset, sampled at posedge clk, forces:
  - state IDLE;
  - lo=0, hi=255;
  - o_guess=0, o_enter=0, o_done=0, o_fail=0, o_count=0;
  - WAIT counter cleared.
REQ-030 Reset has priority over every other input, including in the middle of a search.
REQ-031 After reset deasserts, the block stays in IDLE until i_start=1.

Verification
REQ-032 Secret 127 emulated, i_start pulse -> one o_enter with o_guess=127, o_done=1, o_count=1.
REQ-033 Secret 0 -> guesses 127,63,31,15,7,3,1,0; o_done=1; o_count=8; o_enter pulses spaced 3+RESP_LAT cycles apart.
REQ-034 Secret 255 -> guesses 127,191,223,239,247,251,253,254,255; o_done=1; o_count=9.
REQ-035 Feedback i_over=1 and i_under=1 together at the first EVAL -> o_fail=1, o_count=1, o_guess=127 held.
REQ-036 Responder always returns i_under=1 -> guess reaches 255, then FAIL at that EVAL; o_count=9.
REQ-037 Reset asserted during WAIT of the 3rd guess -> next cycle IDLE, all outputs 0. A following i_start then restarts the search with o_guess=127, o_count=1.

Source files
------------

// File: rtl/auto_guesser.sv
// Binary-search guesser: submits guesses to an external responder and narrows
// the [lo, hi] window from over/under/equal feedback until it hits or faults.
module auto_guesser #(
  parameter int RESP_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_over,
  input  logic       i_under,
  input  logic       i_equal,
  output logic [7:0] o_guess,
  output logic       o_enter,
  output logic       o_done,
  output logic       o_fail,
  output logic [3:0] o_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ENTER = 3'd2,
    WAIT  = 3'd3,
    EVAL  = 3'd4,
    DONE  = 3'd5,
    FAIL  = 3'd6
  } state_t;

  localparam logic [3:0] WAIT_LAST   = 4'(RESP_LAT - 1);
  localparam logic [7:0] START_GUESS = 8'd127;

  state_t     state_r;
  logic [7:0] lo_r;
  logic [7:0] hi_r;
  logic [3:0] wait_cnt_r;

  logic       onehot_s;
  logic       eval_fail_s;
  logic [7:0] new_lo_s;
  logic [7:0] new_hi_s;
  logic [7:0] guess_dec_s;
  logic [7:0] guess_inc_s;
  logic [8:0] sum_s;
  logic [7:0] next_guess_s;

  // Feedback evaluation: window update and fault detection for the EVAL cycle.
  always_comb begin
    onehot_s    = ({i_over, i_under, i_equal} == 3'b100) ||
                  ({i_over, i_under, i_equal} == 3'b010) ||
                  ({i_over, i_under, i_equal} == 3'b001);
    guess_dec_s = o_guess - 8'd1;
    guess_inc_s = o_guess + 8'd1;
    eval_fail_s = 1'b0;
    new_lo_s    = lo_r;
    new_hi_s    = hi_r;
    if (!onehot_s) begin
      eval_fail_s = 1'b1;
    end else if (i_equal) begin
      eval_fail_s = 1'b0;
    end else if (o_count == 4'd15) begin
      eval_fail_s = 1'b1;
    end else if (i_over) begin
      if ((o_guess == 8'd0) || (lo_r > guess_dec_s)) begin
        eval_fail_s = 1'b1;
      end else begin
        new_hi_s = guess_dec_s;
      end
    end else begin
      if ((o_guess == 8'd255) || (guess_inc_s > hi_r)) begin
        eval_fail_s = 1'b1;
      end else begin
        new_lo_s = guess_inc_s;
      end
    end
    sum_s        = {1'b0, new_lo_s} + {1'b0, new_hi_s};
    next_guess_s = sum_s[8:1];
  end

  // Search sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      lo_r       <= 8'd0;
      hi_r       <= 8'd255;
      wait_cnt_r <= 4'd0;
      o_guess    <= 8'd0;
      o_enter    <= 1'b0;
      o_done     <= 1'b0;
      o_fail     <= 1'b0;
      o_count    <= 4'd0;
    end else begin
      o_enter <= 1'b0;
      case (state_r)
        IDLE, DONE, FAIL: begin
          if (i_start) begin
            state_r <= SETUP;
            lo_r    <= 8'd0;
            hi_r    <= 8'd255;
            o_guess <= START_GUESS;
            o_count <= 4'd0;
            o_done  <= 1'b0;
            o_fail  <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        SETUP: begin
          state_r <= ENTER;
          o_enter <= 1'b1;
          o_count <= o_count + 4'd1;
        end
        ENTER: begin
          state_r    <= WAIT;
          wait_cnt_r <= 4'd0;
        end
        WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r <= EVAL;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        EVAL: begin
          if (eval_fail_s) begin
            state_r <= FAIL;
            o_fail  <= 1'b1;
          end else if (i_equal) begin
            state_r <= DONE;
            o_done  <= 1'b1;
          end else begin
            state_r <= SETUP;
            lo_r    <= new_lo_s;
            hi_r    <= new_hi_s;
            o_guess <= next_guess_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auto_guesser.sv
// Self-checking bench for auto_guesser: a scripted responder plus a
// window-arithmetic model of the expected guess sequence and outcome.
module tb_auto_guesser;

  localparam int R = 2;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic       i_over;
  logic       i_under;
  logic       i_equal;
  logic [7:0] o_guess;
  logic       o_enter;
  logic       o_done;
  logic       o_fail;
  logic [3:0] o_count;

  int checks_r;
  int errors_r;

  auto_guesser #(.RESP_LAT(R)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (i_start),
    .i_over  (i_over),
    .i_under (i_under),
    .i_equal (i_equal),
    .o_guess (o_guess),
    .o_enter (o_enter),
    .o_done  (o_done),
    .o_fail  (o_fail),
    .o_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks_r++;
    if (got != exp) begin
      errors_r++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Responder modes: 0 honest, 1 always under, 2 over+under, 3 silent, 4 parity liar.
  function automatic logic [2:0] resp(input int mode, input int secret, input int g);
    case (mode)
      0:       return (g > secret) ? 3'b100 : ((g < secret) ? 3'b010 : 3'b001);
      1:       return 3'b010;
      2:       return 3'b110;
      3:       return 3'b000;
      4:       return (g % 2 == 1) ? 3'b100 : 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  int exp_q[$];
  bit exp_done;

  // Plain binary search over an integer window, following the feedback rules.
  task automatic build_model(input int mode, input int secret);
    int lo, hi, g, n;
    logic [2:0] f;
    lo = 0; hi = 255; n = 0;
    exp_q.delete();
    exp_done = 1'b0;
    forever begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      n++;
      f = resp(mode, secret, g);
      if (f == 3'b001) begin exp_done = 1'b1; break; end
      if (f != 3'b100 && f != 3'b010) break;
      if (n == 15) break;
      if (f == 3'b100) begin
        if (g == 0 || lo > g - 1) break;
        hi = g - 1;
      end else begin
        if (g == 255 || g + 1 > hi) break;
        lo = g + 1;
      end
    end
  endtask

  task automatic run_search(input int mode, input int secret);
    int n, last_enter;
    bit finished;
    logic [2:0] f;
    build_model(mode, secret);
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    n = 0; last_enter = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      f = resp(mode, secret, int'(o_guess));
      {i_over, i_under, i_equal} = f;
      if (o_enter) begin
        if (n > 0) check("enter_gap", cyc - last_enter, 3 + R);
        if (n < exp_q.size()) check("guess", int'(o_guess), exp_q[n]);
        else check("extra_guess", n, exp_q.size() - 1);
        n++;
        check("count_at_enter", int'(o_count), n);
        last_enter = cyc;
      end
      if (o_done || o_fail) begin
        finished = 1'b1;
        i_start  = 1'b0;
      end else begin
        i_start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    i_start = 1'b0;
    check("timeout", int'(finished), 1);
    check("done", int'(o_done), int'(exp_done));
    check("fail", int'(o_fail), int'(!exp_done));
    check("num_guesses", n, exp_q.size());
    check("final_count", int'(o_count), exp_q.size());
    check("final_guess", int'(o_guess), exp_q[exp_q.size() - 1]);
    repeat (3) @(negedge clk);
    check("hold_guess", int'(o_guess), exp_q[exp_q.size() - 1]);
    check("hold_count", int'(o_count), exp_q.size());
    check("hold_enter", int'(o_enter), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_guess"}, int'(o_guess), 0);
    check({tag, "_enter"}, int'(o_enter), 0);
    check({tag, "_done"},  int'(o_done), 0);
    check({tag, "_fail"},  int'(o_fail), 0);
    check({tag, "_count"}, int'(o_count), 0);
  endtask

  initial begin
    int enters;
    bit seen;
    checks_r = 0; errors_r = 0;
    reset = 1'b1; i_start = 1'b0;
    i_over = 1'b0; i_under = 1'b0; i_equal = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("reset");
    repeat (4) @(negedge clk);
    check_outputs_zero("idle_hold");

    run_search(0, 127);
    run_search(0, 0);
    run_search(0, 255);
    run_search(1, 0);
    run_search(2, 0);
    run_search(3, 0);
    run_search(4, 0);
    for (int i = 0; i < 20; i++) run_search(0, int'($urandom_range(0, 255)));

    // Reset during WAIT of the third guess, then a clean restart.
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    enters = 0;
    for (int cyc = 0; cyc < 100 && enters < 3; cyc++) begin
      {i_over, i_under, i_equal} = resp(0, 0, int'(o_guess));
      if (o_enter) enters++;
      if (enters < 3) @(negedge clk);
    end
    check("third_enter_seen", enters, 3);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    reset = 1'b0;
    i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      if (o_enter) seen = 1'b1;
      else @(negedge clk);
    end
    check("restart_enter", int'(seen), 1);
    check("restart_guess", int'(o_guess), 127);
    check("restart_count", int'(o_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
